// File: rtl/ram2_ctrl.sv
// Arbitrating IF/MEM access sequencer in front of the RAM2 SRAM driver (IDLE -> ACCESS -> DONE).
// Define RAM2_POSTED_WR_EN to add a one-entry posted write buffer for MEM writes.
module ram2_ctrl #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_MEM, OWN_WB} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_read_q, ram_read_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] rd_cap_q, rd_cap_d;
`ifdef RAM2_POSTED_WR_EN
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_read_d   = ram_read_q;
    if_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_ack_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    starve_cnt_d = starve_cnt_q;
`ifdef RAM2_POSTED_WR_EN
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_cnt_d = '0;
`ifdef RAM2_POSTED_WR_EN
        // A buffered write drains before anything else so MEM ordering holds without forwarding.
        if (wb_valid_q) begin
          state_d    = ACCESS;
          owner_d    = OWN_WB;
          ram_addr_d = wb_addr_q;
          ram_data_d = wb_data_q;
          ram_read_d = 1'b1;
        end else
`endif
        if (mem_req && !(if_req && starve_cnt_q == LIMIT)) begin
          if (if_req) starve_cnt_d = (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : LIMIT;
`ifdef RAM2_POSTED_WR_EN
          // Posting reuses DONE as the ack cycle, so the held request is ignored there.
          if (mem_we) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = mem_addr;
            wb_data_d  = mem_wdata;
            mem_ack_d  = 1'b1;
            owner_d    = OWN_MEM;
            state_d    = DONE;
          end else
`endif
          begin
            state_d    = ACCESS;
            owner_d    = OWN_MEM;
            ram_addr_d = mem_addr;
            ram_read_d = mem_we;
            if (mem_we) ram_data_d = mem_wdata;
          end
        end else if (if_req) begin
          starve_cnt_d = '0;
          state_d      = ACCESS;
          owner_d      = OWN_IF;
          ram_addr_d   = if_addr;
          ram_read_d   = 1'b0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        unique case (owner_q)
          OWN_IF: begin
            if_ack_d   = 1'b1;
            if_rdata_d = rd_cap_q;
          end
          OWN_MEM: begin
            mem_ack_d = 1'b1;
            if (!ram_read_q) mem_rdata_d = rd_cap_q;
          end
          default: begin
`ifdef RAM2_POSTED_WR_EN
            wb_valid_d = 1'b0;
`endif
          end
        endcase
      end
      DONE: begin
        state_d    = IDLE;
        ram_read_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_cap_d = rd_cap_q;
    if (state_q == ACCESS && !ram_read_q) rd_cap_d = ram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_read_q   <= 1'b0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      mem_ack_q    <= 1'b0;
      mem_rdata_q  <= '0;
      starve_cnt_q <= '0;
`ifdef RAM2_POSTED_WR_EN
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_read_q   <= ram_read_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_ack_q    <= mem_ack_d;
      mem_rdata_q  <= mem_rdata_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef RAM2_POSTED_WR_EN
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
`endif
    end
  end

  // Read data is sampled mid-access, after the driver has had the clk-high half to strobe OE.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) rd_cap_q <= '0;
    else     rd_cap_q <= rd_cap_d;
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_read  = ram_read_q;
`ifdef RAM2_POSTED_WR_EN
  assign busy = (state_q != IDLE) || wb_valid_q;
`else
  assign busy = (state_q != IDLE);
`endif

endmodule
